// File: rtl/aes192_iter_engine.sv
`default_nettype none
// aes192_iter_engine: iterative AES-192 encryptor. One shared round datapath and one
// key_expansion_192 step fill and consume a 13-entry round-key buffer (w[0..53]).
module aes192_iter_engine (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [191:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [127:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         key_ok,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, KEXP = 2'd1, ROUND = 2'd2} state_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = SBOX[s[8*i +: 8]];
        return o;
    endfunction

    // Byte (row r, column c) sits at [127-8*(4c+r) -: 8]; row r rotates left by r.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return o;
    endfunction

    function automatic logic [191:0] key_expansion_192(input logic [191:0] ks,
                                                       input logic [31:0]  rcon);
        logic [31:0] t, n0, n1, n2, n3, n4, n5;
        t  = sub_word({ks[23:0], ks[31:24]}) ^ rcon;
        n0 = ks[191:160] ^ t;
        n1 = ks[159:128] ^ n0;
        n2 = ks[127:96]  ^ n1;
        n3 = ks[95:64]   ^ n2;
        n4 = ks[63:32]   ^ n3;
        n5 = ks[31:0]    ^ n4;
        return {n0, n1, n2, n3, n4, n5};
    endfunction

    state_t         fsm_q, fsm_d;
    logic [127:0]   st_q;
    logic [3:0]     rnd_q;
    logic [2:0]     kc_q;
    logic [191:0]   ks_q;
    logic [31:0]    w_q [0:53];
    logic [127:0]   out_data_q;
    logic           out_valid_q;
    logic           key_ok_q;

    logic           key_acc, blk_acc;
    logic [191:0]   ks_nxt;
    logic [5:0]     wr_base, rk_base;
    logic [127:0]   rk, rk0, sr, round_out, final_out;

    assign ks_nxt    = key_expansion_192(ks_q, 32'h01000000 << kc_q);
    assign wr_base   = 6'd6 + 6'd6 * {3'b000, kc_q};
    assign rk_base   = {rnd_q, 2'b00};
    assign rk        = {w_q[rk_base], w_q[rk_base + 6'd1], w_q[rk_base + 6'd2], w_q[rk_base + 6'd3]};
    assign rk0       = {w_q[0], w_q[1], w_q[2], w_q[3]};
    assign sr        = shift_rows(sub_bytes(st_q));
    assign round_out = mix_columns(sr) ^ rk;
    assign final_out = sr ^ rk;

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign key_ok    = key_ok_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fsm_q <= IDLE;
        else        fsm_q <= fsm_d;
    end

    // A pending key always wins over a pending block in IDLE.
    always_comb begin
        fsm_d     = fsm_q;
        key_ready = 1'b0;
        in_ready  = 1'b0;
        busy      = 1'b0;
        key_acc   = 1'b0;
        blk_acc   = 1'b0;
        case (fsm_q)
            IDLE: begin
                key_ready = 1'b1;
                in_ready  = key_ok_q && !out_valid_q && !key_valid;
                if (key_valid) begin
                    key_acc = 1'b1;
                    fsm_d   = KEXP;
                end else if (in_valid && in_ready) begin
                    blk_acc = 1'b1;
                    fsm_d   = ROUND;
                end
            end
            KEXP: begin
                busy = 1'b1;
                if (kc_q == 3'd7) fsm_d = IDLE;
            end
            ROUND: begin
                busy = 1'b1;
                if (rnd_q == 4'd12) fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q        <= '0;
            rnd_q       <= '0;
            kc_q        <= '0;
            ks_q        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            key_ok_q    <= 1'b0;
            for (int i = 0; i < 54; i++) w_q[i] <= '0;
        end else begin
            if (out_valid_q && out_ready) out_valid_q <= 1'b0;

            if (key_acc) begin
                ks_q     <= key_in;
                key_ok_q <= 1'b0;
                kc_q     <= 3'd0;
                for (int j = 0; j < 6; j++) w_q[j] <= key_in[191-32*j -: 32];
            end

            if (fsm_q == KEXP) begin
                ks_q <= ks_nxt;
                kc_q <= kc_q + 3'd1;
                for (int j = 0; j < 6; j++) w_q[wr_base + 6'(j)] <= ks_nxt[191-32*j -: 32];
                if (kc_q == 3'd7) key_ok_q <= 1'b1;
            end

            if (blk_acc) begin
                st_q  <= in_data ^ rk0;
                rnd_q <= 4'd1;
            end

            if (fsm_q == ROUND) begin
                if (rnd_q == 4'd12) begin
                    out_data_q  <= final_out;
                    out_valid_q <= 1'b1;
                    rnd_q       <= 4'd0;
                end else begin
                    st_q  <= round_out;
                    rnd_q <= rnd_q + 4'd1;
                end
            end
        end
    end
endmodule
`default_nettype wire
